// File: rtl/pulpino_spi_slave.sv
// SPI/QPI slave: host access to two config registers and a word memory port.
// SPI pins are oversampled on clk; SCK edges are detected after synchronising.
module pulpino_spi_slave #(
    parameter int DUMMY_RST = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        spi_clk_i,
    input  logic        spi_cs_i,
    input  logic        spi_sdi0_i,
    input  logic        spi_sdi1_i,
    input  logic        spi_sdi2_i,
    input  logic        spi_sdi3_i,
    output logic        spi_sdo0_o,
    output logic        spi_sdo1_o,
    output logic        spi_sdo2_o,
    output logic        spi_sdo3_o,
    output logic [1:0]  spi_mode_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic [31:0] mem_rdata_i
);
    typedef enum logic [3:0] {
        S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_RDATA,
        S_WDATA, S_REGW, S_REGR, S_IGN
    } state_t;

    localparam logic [7:0] C_WR0 = 8'h01;
    localparam logic [7:0] C_RD0 = 8'h05;
    localparam logic [7:0] C_WR1 = 8'h11;
    localparam logic [7:0] C_RD1 = 8'h07;
    localparam logic [7:0] C_MWR = 8'h02;
    localparam logic [7:0] C_MRD = 8'h0B;

    state_t      r_state, w_state_nx;
    logic [2:0]  r_sck_s;
    logic [1:0]  r_cs_s;
    logic [3:0]  r_sdi_s0, r_sdi_s1;
    logic        w_rise, w_fall, w_csh;
    logic [3:0]  w_sdi;
    logic        r_qpi;
    logic [7:0]  r_reg0, r_reg1, r_cmd, r_cnt;
    logic [7:0]  w_cnt_nx, w_len, w_step;
    logic        w_done;
    logic [31:0] r_sr, w_sr_nx;
    logic [31:0] r_tx, w_tx_word;
    logic [5:0]  r_tcnt, w_tcnt_nx, w_tlen, w_tstep;
    logic        w_tx_on, w_load;
    logic        r_req, r_we, r_rbuf_vld;
    logic [31:0] r_addr, r_wdata, r_rbuf;

    // Synchronise SPI pins; third SCK flop is history for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_s  <= 3'b000;
            r_cs_s   <= 2'b11;
            r_sdi_s0 <= 4'h0;
            r_sdi_s1 <= 4'h0;
        end else begin
            r_sck_s  <= {r_sck_s[1:0], spi_clk_i};
            r_cs_s   <= {r_cs_s[0], spi_cs_i};
            r_sdi_s0 <= {spi_sdi3_i, spi_sdi2_i, spi_sdi1_i, spi_sdi0_i};
            r_sdi_s1 <= r_sdi_s0;
        end
    end

    assign w_rise = r_sck_s[1] & ~r_sck_s[2];
    assign w_fall = ~r_sck_s[1] & r_sck_s[2];
    assign w_csh  = r_cs_s[1];
    assign w_sdi  = r_sdi_s1;

    // Receive side: phase length, bits per edge and next shifter value
    always_comb begin
        w_step = r_qpi ? 8'd4 : 8'd1;
        w_len  = 8'd0;
        unique case (r_state)
            S_CMD, S_REGW:   w_len = 8'd8;
            S_ADDR, S_WDATA: w_len = 8'd32;
            S_DUMMY: begin
                w_len  = r_reg1;
                w_step = 8'd1;
            end
            default:         w_len = 8'd0;
        endcase
        w_cnt_nx = r_cnt + w_step;
        w_done   = w_rise && (w_len != 8'd0) && (w_cnt_nx == w_len);
        w_sr_nx  = r_qpi ? {r_sr[27:0], w_sdi} : {r_sr[30:0], w_sdi[0]};
    end

    // Transmit side: word to load at the start of each output word
    always_comb begin
        w_tx_on   = (r_state == S_REGR) || (r_state == S_RDATA);
        w_tlen    = (r_state == S_REGR) ? 6'd8 : 6'd32;
        w_tstep   = r_qpi ? 6'd4 : 6'd1;
        w_tcnt_nx = r_tcnt + w_tstep;
        w_load    = w_tx_on && w_fall && (r_tcnt == 6'd0);
        w_tx_word = 32'h0;
        if (r_state == S_REGR)
            w_tx_word = {(r_cmd == C_RD0) ? r_reg0 : r_reg1, 24'h0};
        else if (r_rbuf_vld)
            w_tx_word = r_rbuf;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    // Next state: CS high always wins and returns to idle
    always_comb begin
        w_state_nx = r_state;
        if (w_csh) begin
            w_state_nx = S_IDLE;
        end else begin
            unique case (r_state)
                S_IDLE: w_state_nx = S_CMD;
                S_CMD: begin
                    if (w_done) begin
                        unique case (w_sr_nx[7:0])
                            C_WR0, C_WR1: w_state_nx = S_REGW;
                            C_RD0, C_RD1: w_state_nx = S_REGR;
                            C_MWR, C_MRD: w_state_nx = S_ADDR;
                            default:      w_state_nx = S_IGN;
                        endcase
                    end
                end
                S_ADDR: begin
                    if (w_done) begin
                        if (r_cmd == C_MWR)       w_state_nx = S_WDATA;
                        else if (r_reg1 == 8'd0)  w_state_nx = S_RDATA;
                        else                      w_state_nx = S_DUMMY;
                    end
                end
                S_DUMMY: if (w_done) w_state_nx = S_RDATA;
                S_REGW:  if (w_done) w_state_nx = S_IGN;
                default: w_state_nx = r_state;
            endcase
        end
    end

    // Datapath: shifters, registers and the memory request port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_qpi      <= 1'b0;
            r_reg0     <= 8'h00;
            r_reg1     <= 8'(DUMMY_RST);
            r_cmd      <= 8'h00;
            r_cnt      <= 8'd0;
            r_sr       <= 32'h0;
            r_tx       <= 32'h0;
            r_tcnt     <= 6'd0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0;
            r_wdata    <= 32'h0;
            r_rbuf     <= 32'h0;
            r_rbuf_vld <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                r_qpi      <= r_reg0[0];
                r_rbuf_vld <= 1'b0;
            end
            if (w_csh || r_state == S_IDLE) begin
                r_cnt <= 8'd0;
            end else if (w_rise) begin
                r_sr  <= w_sr_nx;
                r_cnt <= w_done ? 8'd0 : w_cnt_nx;
            end
            if (!w_tx_on) begin
                r_tcnt <= 6'd0;
                r_tx   <= 32'h0;
            end else if (w_fall) begin
                r_tcnt <= (w_tcnt_nx == w_tlen) ? 6'd0 : w_tcnt_nx;
                if (w_load)     r_tx <= w_tx_word;
                else if (r_qpi) r_tx <= r_tx << 4;
                else            r_tx <= r_tx << 1;
            end
            if (w_load && r_state == S_RDATA) begin
                r_rbuf_vld <= 1'b0;
                if (!r_req) begin
                    r_req <= 1'b1;
                    r_we  <= 1'b0;
                end
            end
            if (r_req && mem_gnt_i) begin
                r_req  <= 1'b0;
                r_addr <= r_addr + 32'd4;
                if (!r_we && (r_state == S_DUMMY || r_state == S_RDATA)) begin
                    r_rbuf     <= mem_rdata_i;
                    r_rbuf_vld <= 1'b1;
                end
            end
            if (w_done && !w_csh) begin
                unique case (r_state)
                    S_CMD: r_cmd <= w_sr_nx[7:0];
                    S_ADDR: begin
                        r_addr <= {w_sr_nx[31:2], 2'b00};
                        if (r_cmd == C_MRD && !r_req) begin
                            r_req <= 1'b1;
                            r_we  <= 1'b0;
                        end
                    end
                    S_WDATA: begin
                        if (!r_req) begin
                            r_req   <= 1'b1;
                            r_we    <= 1'b1;
                            r_wdata <= w_sr_nx;
                        end
                    end
                    S_REGW: begin
                        if (r_cmd == C_WR0) r_reg0 <= w_sr_nx[7:0];
                        else                r_reg1 <= w_sr_nx[7:0];
                    end
                    default: r_cmd <= r_cmd;
                endcase
            end
        end
    end

    // Pad direction: turn around one SCK before read data leaves
    always_comb begin
        spi_mode_o = 2'b00;
        if (r_qpi) begin
            spi_mode_o = 2'b10;
            if (w_tx_on ||
                (r_state == S_DUMMY && r_cnt == r_reg1 - 8'd1))
                spi_mode_o = 2'b01;
        end
    end

    assign spi_sdo0_o  = w_tx_on & r_qpi & r_tx[28];
    assign spi_sdo1_o  = w_tx_on & (r_qpi ? r_tx[29] : r_tx[31]);
    assign spi_sdo2_o  = w_tx_on & r_qpi & r_tx[30];
    assign spi_sdo3_o  = w_tx_on & r_qpi & r_tx[31];
    assign mem_req_o   = r_req;
    assign mem_we_o    = r_we;
    assign mem_addr_o  = r_addr;
    assign mem_wdata_o = r_wdata;
endmodule

// File: tb/tb_pulpino_spi_slave.sv
// Bench for pulpino_spi_slave: a host SPI/QPI driver, a random-latency
// memory and a word-level reference of registers and memory contents.
module tb_pulpino_spi_slave;
    localparam int H = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sck = 1'b0;
    logic        cs = 1'b1;
    logic        sdi0 = 1'b0, sdi1 = 1'b0, sdi2 = 1'b0, sdi3 = 1'b0;
    logic        sdo0, sdo1, sdo2, sdo3;
    logic [1:0]  mode;
    logic        mem_req, mem_we, mem_gnt = 1'b0;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = 32'h0;

    int n_vec = 0;
    int n_err = 0;
    bit quad = 1'b0;
    bit sdo_any;
    int n_req = 0;
    bit prev_req = 1'b0;
    int lat = 0;

    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [63:0] wr_q [$];
    logic [63:0] exp_wr [$];

    pulpino_spi_slave #(.DUMMY_RST(32)) dut (
        .clk(clk), .rst(rst),
        .spi_clk_i(sck), .spi_cs_i(cs),
        .spi_sdi0_i(sdi0), .spi_sdi1_i(sdi1),
        .spi_sdi2_i(sdi2), .spi_sdi3_i(sdi3),
        .spi_sdo0_o(sdo0), .spi_sdo1_o(sdo1),
        .spi_sdo2_o(sdo2), .spi_sdo3_o(sdo3),
        .spi_mode_o(mode),
        .mem_req_o(mem_req), .mem_we_o(mem_we),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_gnt_i(mem_gnt), .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    // Memory: grants after 0..4 cycles, logs writes
    always @(negedge clk) begin
        if (mem_req && !prev_req) n_req++;
        prev_req = mem_req;
        if (rst) begin
            mem_gnt = 1'b0;
        end else if (mem_gnt) begin
            mem_gnt = 1'b0;
        end else if (mem_req) begin
            if (lat == 0) begin
                mem_gnt = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_q.push_back({mem_addr, mem_wdata});
                end else begin
                    mem_rdata = mem.exists(mem_addr) ? mem[mem_addr] : 32'h0;
                end
                lat = $urandom_range(0, 4);
            end else begin
                lat--;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int st(input int bits);
        return quad ? bits / 4 : bits;
    endfunction

    task automatic xfer(input int n, input logic [31:0] dout,
                        output logic [31:0] din);
        din = 32'h0;
        for (int k = 0; k < n; k++) begin
            if (quad) begin
                {sdi3, sdi2, sdi1, sdi0} = dout[31:28];
                dout = dout << 4;
            end else begin
                sdi0 = dout[31];
                dout = dout << 1;
            end
            repeat (H) @(negedge clk);
            if (quad) din = {din[27:0], sdo3, sdo2, sdo1, sdo0};
            else      din = {din[30:0], sdo1};
            sdo_any |= sdo0 | sdo1 | sdo2 | sdo3;
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
    endtask

    task automatic cs_low();
        {sdi3, sdi2, sdi1, sdi0} = 4'h0;
        cs = 1'b0;
        repeat (H) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (H) @(negedge clk);
        cs = 1'b1;
        repeat (3 * H) @(negedge clk);
    endtask

    task automatic reg_wr(input logic [7:0] cmd, input logic [7:0] val);
        logic [31:0] d;
        cs_low();
        xfer(st(8), {cmd, 24'h0}, d);
        xfer(st(8), {val, 24'h0}, d);
        cs_high();
    endtask

    task automatic reg_rd(input logic [7:0] cmd, output logic [7:0] val);
        logic [31:0] d;
        cs_low();
        xfer(st(8), {cmd, 24'h0}, d);
        xfer(st(8), 32'h0, d);
        val = d[7:0];
        cs_high();
    endtask

    task automatic mem_wr(input logic [31:0] a, input logic [31:0] w[$]);
        logic [31:0] d;
        cs_low();
        xfer(st(8), {8'h02, 24'h0}, d);
        xfer(st(32), a, d);
        foreach (w[i]) begin
            xfer(st(32), w[i], d);
            ref_mem[a + 32'(4 * i)] = w[i];
            exp_wr.push_back({a + 32'(4 * i), w[i]});
        end
        cs_high();
    endtask

    task automatic wait_wr();
        int t = 0;
        while (wr_q.size() < exp_wr.size() && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk("wr_count", 32'(wr_q.size()), 32'(exp_wr.size()));
        for (int i = 0; i < exp_wr.size() && i < wr_q.size(); i++) begin
            chk("wr_addr", wr_q[i][63:32], exp_wr[i][63:32]);
            chk("wr_data", wr_q[i][31:0], exp_wr[i][31:0]);
        end
        wr_q.delete();
        exp_wr.delete();
    endtask

    task automatic mem_rd(input logic [31:0] a, input int dummy,
                          input int nw, input bit chk_mode);
        logic [31:0] d;
        cs_low();
        xfer(st(8), {8'h0B, 24'h0}, d);
        xfer(st(32), a, d);
        if (chk_mode) chk("mode_dummy", 32'(mode), 32'(2'b10));
        xfer(dummy, 32'h0, d);
        if (chk_mode) chk("mode_rdata", 32'(mode), 32'(2'b01));
        for (int i = 0; i < nw; i++) begin
            xfer(st(32), 32'h0, d);
            chk("rd_word", d, ref_mem[a + 32'(4 * i)]);
        end
        cs_high();
    endtask

    logic [7:0]  v, r0, r1;
    logic [31:0] d, base;
    logic [31:0] ws[$];
    int          snap;

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_mode", 32'(mode), 32'h0);
        chk("rst_sdo", 32'({sdo3, sdo2, sdo1, sdo0}), 32'h0);
        chk("rst_req", 32'(mem_req), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        reg_rd(8'h07, v);
        chk("reg1_rst", 32'(v), 32'h20);
        r1 = 8'h08;
        reg_wr(8'h11, r1);
        reg_rd(8'h07, v);
        chk("reg1_wr", 32'(v), 32'(r1));

        r0 = 8'h01;
        reg_wr(8'h01, r0);
        quad = 1'b1;
        cs_low();
        chk("mode_cmd", 32'(mode), 32'(2'b10));
        xfer(2, {8'h05, 24'h0}, d);
        chk("mode_regr", 32'(mode), 32'(2'b01));
        xfer(2, 32'h0, d);
        chk("reg0_quad", 32'(d[7:0]), 32'(r0));
        cs_high();

        r0 = {7'($urandom), 1'b1};
        reg_wr(8'h01, r0);
        reg_rd(8'h05, v);
        chk("reg0_rand", 32'(v), 32'(r0));

        r1 = 8'h20;
        reg_wr(8'h11, r1);
        ws = '{32'hDEADBEEF, 32'h12345678};
        mem_wr(32'h1000, ws);
        wait_wr();
        mem_rd(32'h1000, 32, 2, 1'b1);

        base = 32'h4000 + 32'($urandom_range(0, 63)) * 4;
        ws = '{$urandom, $urandom, $urandom};
        mem_wr(base, ws);
        wait_wr();
        r1 = 8'($urandom_range(8, 16));
        reg_wr(8'h11, r1);
        reg_rd(8'h07, v);
        chk("reg1_rand", 32'(v), 32'(r1));
        mem_rd(base + 32'($urandom_range(0, 1)) * 4, int'(r1), 2, 1'b0);

        snap = n_req;
        cs_low();
        xfer(2, {8'h02, 24'h0}, d);
        xfer(8, 32'h2000, d);
        xfer(5, $urandom, d);
        cs_high();
        repeat (30) @(negedge clk);
        chk("partial_req", 32'(n_req), 32'(snap));
        chk("partial_wr", 32'(wr_q.size()), 32'h0);
        reg_rd(8'h05, v);
        chk("after_partial", 32'(v), 32'(r0));

        do v = 8'($urandom);
        while (v inside {8'h01, 8'h05, 8'h11, 8'h07, 8'h02, 8'h0B});
        sdo_any = 1'b0;
        cs_low();
        xfer(2, {v, 24'h0}, d);
        xfer(6, $urandom, d);
        cs_high();
        chk("ign_sdo", 32'(sdo_any), 32'h0);
        reg_rd(8'h07, v);
        chk("after_ign", 32'(v), 32'(r1));

        snap = n_req;
        cs_low();
        xfer(2, {8'h02, 24'h0}, d);
        xfer(8, 32'h3000, d);
        xfer(4, $urandom, d);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("mrst_mode", 32'(mode), 32'h0);
        chk("mrst_req", 32'(mem_req), 32'h0);
        chk("mrst_addr", mem_addr, 32'h0);
        chk("mrst_wdata", mem_wdata, 32'h0);
        chk("mrst_sdo", 32'({sdo3, sdo2, sdo1, sdo0}), 32'h0);
        cs = 1'b1;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        quad = 1'b0;
        repeat (30) @(negedge clk);
        chk("mrst_noreq", 32'(n_req), 32'(snap));
        reg_rd(8'h05, v);
        chk("mrst_reg0", 32'(v), 32'h00);
        reg_rd(8'h07, v);
        chk("mrst_reg1", 32'(v), 32'h20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
